// File: rtl/sweep_ctrl1_1_if.sv
// sweep_ctrl1_1_if: START/X handshake plus {A,B,C} drive and result bus of the sweep controller.
// Latency: none (wires only).
// Backpressure: none; the host observes BUSY/DONE, the controller ignores START while busy.
interface sweep_ctrl1_1_if;
    logic       START;
    logic       A;
    logic       B;
    logic       C;
    logic       X;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       ERR;
    logic [3:0] ERRCNT;

    // Controller side: drives the datapath inputs and reports results.
    modport master (
        input  START, X,
        output A, B, C, BUSY, DONE, RESULT, ERR, ERRCNT
    );

    // Host/datapath side: requests sweeps and returns X.
    modport slave (
        output START, X,
        input  A, B, C, BUSY, DONE, RESULT, ERR, ERRCNT
    );
endinterface

// File: rtl/sweep_ctrl1_1.sv
// sweep_ctrl1_1: drives {A,B,C} = 0..7 in order, samples X once per vector into RESULT.
// Latency: accept edge t0 -> DONE pulse at t0 + 8*(SETTLE+1); vector i held SETTLE+1 cycles.
// Backpressure: none; START is ignored while BUSY, honoured in IDLE and at the FINISH closing edge.
// Build option: SWEEP_COMPARE_EN adds the golden compare (ERR, ERRCNT); otherwise both tie to 0.
module sweep_ctrl1_1 #(
    parameter int unsigned SETTLE = 2,     // 1..15 cycles of DRIVE before SAMPLE
    parameter logic [7:0]  GOLDEN = 8'h90  // expected X, bit i for {A,B,C} = i
) (
    input  logic            CLK,
    input  logic            RST_N,
    sweep_ctrl1_1_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q,   vec_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] result_q, result_d;
    logic [2:0] abc_q,   abc_d;
`ifdef SWEEP_COMPARE_EN
    logic [3:0] errcnt_q, errcnt_d;
    logic       err_q,    err_d;
`endif

    // Next-state, sampling and launch logic for the sweep sequencer.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef SWEEP_COMPARE_EN
        errcnt_d = errcnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d  = DRIVE;
                    vec_d    = 3'd0;
                    cnt_d    = 4'd0;
                    result_d = 8'h00;
`ifdef SWEEP_COMPARE_EN
                    errcnt_d = 4'd0;
                    err_d    = 1'b0;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == SettleLast) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                result_d[vec_q] = bus.X;
`ifdef SWEEP_COMPARE_EN
                if (bus.X != GOLDEN[vec_q]) begin
                    errcnt_d = errcnt_q + 4'd1;
                end
`endif
                if (vec_q == 3'd7) begin
                    state_d = FINISH;
`ifdef SWEEP_COMPARE_EN
                    // Loaded on entry so ERR is already valid alongside DONE.
                    err_d = (errcnt_d != 4'd0);
`endif
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            FINISH: begin
                state_d = IDLE;
                // A START held high re-launches on the edge leaving FINISH,
                // giving back-to-back sweeps 8*(SETTLE+1)+1 edges apart.
                if (bus.START) begin
                    state_d  = DRIVE;
                    vec_d    = 3'd0;
                    cnt_d    = 4'd0;
                    result_d = 8'h00;
`ifdef SWEEP_COMPARE_EN
                    errcnt_d = 4'd0;
                    err_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Datapath drive follows the vector only while a vector is active.
        abc_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? vec_d : 3'd0;
    end

    // State and datapath registers; reset aborts any sweep with no DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            vec_q    <= 3'd0;
            cnt_q    <= 4'd0;
            result_q <= 8'h00;
            abc_q    <= 3'd0;
`ifdef SWEEP_COMPARE_EN
            errcnt_q <= 4'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            abc_q    <= abc_d;
`ifdef SWEEP_COMPARE_EN
            errcnt_q <= errcnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.A      = abc_q[2];
    assign bus.B      = abc_q[1];
    assign bus.C      = abc_q[0];
    assign bus.BUSY   = (state_q == DRIVE) || (state_q == SAMPLE);
    assign bus.DONE   = (state_q == FINISH);
    assign bus.RESULT = result_q;
`ifdef SWEEP_COMPARE_EN
    assign bus.ERR    = err_q;
    assign bus.ERRCNT = errcnt_q;
`else
    // GOLDEN has no role without compare; masking it keeps the parameter referenced.
    assign bus.ERR    = ^(GOLDEN & 8'h00);
    assign bus.ERRCNT = 4'd0;
`endif

endmodule

// File: tb/tb_sweep_ctrl1_1.sv
// tb_sweep_ctrl1_1: checks sweep_ctrl1_1 (SETTLE=2 and SETTLE=1) against a timing-formula model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sweep_ctrl1_1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sweep_ctrl1_1_if if2 ();
    sweep_ctrl1_1_if if1 ();

    sweep_ctrl1_1 #(.SETTLE(2), .GOLDEN(8'h90)) u_dut_s2 (.CLK(clk), .RST_N(rst_n), .bus(if2));
    sweep_ctrl1_1 #(.SETTLE(1), .GOLDEN(8'h90)) u_dut_s1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

    int         checks = 0;
    int         errors = 0;
    int         sel    = 2;     // which DUT is under test: 2 -> SETTLE=2, 1 -> SETTLE=1
    int         mode   = 2;     // X source: 0 real gate, 1 stuck-1, 2 stuck-0, 3 random
    logic       rnd_x  = 1'b0;
    logic [7:0] gold_v = 8'h90;
    logic       s_a, s_b, s_c, x_drv;

    always_comb begin
        if (sel == 1) {s_a, s_b, s_c} = {if1.A, if1.B, if1.C};
        else          {s_a, s_b, s_c} = {if2.A, if2.B, if2.C};
    end

    always_comb begin
        case (mode)
            0:       x_drv = s_a & ~(s_b ^ s_c);
            1:       x_drv = 1'b1;
            2:       x_drv = 1'b0;
            default: x_drv = rnd_x;
        endcase
    end

    assign if1.X = x_drv;
    assign if2.X = x_drv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic gate(input int v);
        logic [2:0] t;
        t = v[2:0];
        return t[2] & ~(t[1] ^ t[0]);
    endfunction

    task automatic get_obs(output logic [2:0] abc, output logic busy, output logic done,
                           output logic [7:0] res, output logic err, output logic [3:0] ec);
        if (sel == 1) begin
            abc = {if1.A, if1.B, if1.C}; busy = if1.BUSY; done = if1.DONE;
            res = if1.RESULT; err = if1.ERR; ec = if1.ERRCNT;
        end else begin
            abc = {if2.A, if2.B, if2.C}; busy = if2.BUSY; done = if2.DONE;
            res = if2.RESULT; err = if2.ERR; ec = if2.ERRCNT;
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) if1.START = v;
        else        if2.START = v;
    endtask

    // All outputs of the selected DUT at zero.
    task automatic check_zero(input string tag);
        logic [2:0] abc; logic busy, done, err; logic [7:0] res; logic [3:0] ec;
        get_obs(abc, busy, done, res, err, ec);
        chk({tag, "_abc"},    32'(abc),  32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_result"}, 32'(res),  32'd0);
        chk({tag, "_err"},    32'(err),  32'd0);
        chk({tag, "_errcnt"}, 32'(ec),   32'd0);
    endtask

    // n idle cycles: nothing moves, results hold.
    task automatic idle_check(input int n, input logic [7:0] res_e, input logic [3:0] ec_e, input logic err_e);
        logic [2:0] abc; logic busy, done, err; logic [7:0] res; logic [3:0] ec;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            get_obs(abc, busy, done, res, err, ec);
            chk("idle_abc",    32'(abc),  32'd0);
            chk("idle_busy",   32'(busy), 32'd0);
            chk("idle_done",   32'(done), 32'd0);
            chk("idle_result", 32'(res),  32'(res_e));
            chk("idle_errcnt", 32'(ec),   32'(ec_e));
            chk("idle_err",    32'(err),  32'(err_e));
        end
    endtask

    // One sweep on DUT s; every cycle from t0 to the DONE cycle compared with the model.
    task automatic run_sweep(input int s, input int settle, input int md, input bit keep,
                             output logic [7:0] res_o, output logic [3:0] ec_o, output logic err_o);
        int per, last, i, ec_m;
        logic [7:0] res_m;
        logic err_m, xcap;
        logic [2:0] abc; logic busy, done, err; logic [7:0] res; logic [3:0] ec;
        per = settle + 1; last = 8 * per;
        res_m = 8'h00; ec_m = 0; err_m = 1'b0; xcap = 1'b0;
        sel = s; mode = md;
        set_start(s, 1'b1);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (k > 0 && (k % per) == 0) begin
                i = k / per - 1;
                res_m[i] = xcap;
                if (xcap !== gold_v[i]) ec_m++;
            end
            if (k == last) err_m = (ec_m != 0);
            if (k == 0 && !keep) set_start(s, 1'b0);
            get_obs(abc, busy, done, res, err, ec);
            chk("sweep_abc",    32'(abc),  (k < last) ? (k / per) : 0);
            chk("sweep_busy",   32'(busy), 32'(k < last));
            chk("sweep_done",   32'(done), 32'(k == last));
            chk("sweep_result", 32'(res),  32'(res_m));
`ifdef SWEEP_COMPARE_EN
            chk("sweep_errcnt", 32'(ec),   ec_m);
            chk("sweep_err",    32'(err),  32'(err_m));
`else
            chk("sweep_errcnt", 32'(ec),   32'd0);
            chk("sweep_err",    32'(err),  32'd0);
`endif
            if (md == 3) rnd_x = 1'($urandom);
            if (((k + 1) % per) == 0 && k < last) begin
                i = (k + 1) / per - 1;
                case (md)
                    0:       xcap = gate(i);
                    1:       xcap = 1'b1;
                    2:       xcap = 1'b0;
                    default: xcap = rnd_x;
                endcase
            end
        end
        res_o = res_m;
`ifdef SWEEP_COMPARE_EN
        ec_o = 4'(ec_m); err_o = err_m;
`else
        ec_o = 4'd0; err_o = 1'b0;
`endif
    endtask

    initial begin
        logic [7:0] r; logic [3:0] e; logic er;
        logic [2:0] abc; logic busy, done, err; logic [7:0] res; logic [3:0] ec;

        // Reset held with START high: nothing may start.
        if1.START = 1'b1; if2.START = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 2; check_zero("rst_s2");
        sel = 1; check_zero("rst_s1");
        @(negedge clk);
        if1.START = 1'b0; if2.START = 1'b0;
        rst_n = 1'b1;
        sel = 2;
        idle_check(10, 8'h00, 4'd0, 1'b0);

        // Nominal sweep with the real gate.
        run_sweep(2, 2, 0, 1'b0, r, e, er);
        get_obs(abc, busy, done, res, err, ec);
        chk("nominal_result", 32'(res), 32'h90);
        chk("nominal_err",    32'(err), 32'd0);
        idle_check(3, r, e, er);

        // X stuck at 1.
        run_sweep(2, 2, 1, 1'b0, r, e, er);
        get_obs(abc, busy, done, res, err, ec);
        chk("stuck1_result", 32'(res), 32'hFF);
`ifdef SWEEP_COMPARE_EN
        chk("stuck1_errcnt", 32'(ec),  32'd6);
        chk("stuck1_err",    32'(err), 32'd1);
`else
        chk("stuck1_errcnt", 32'(ec),  32'd0);
        chk("stuck1_err",    32'(err), 32'd0);
`endif
        idle_check(3, r, e, er);

        // START held high on SETTLE=1: back-to-back sweeps 17 edges apart.
        run_sweep(1, 1, 0, 1'b1, r, e, er);
        run_sweep(1, 1, 0, 1'b0, r, e, er);
        idle_check(6, r, e, er);

        // Reset abort while vector 3 is driven.
        sel = 2; mode = 0;
        if2.START = 1'b1;
        @(posedge clk); #1;
        if2.START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        get_obs(abc, busy, done, res, err, ec);
        chk("abort_pre_abc", 32'(abc), 32'd3);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(30, 8'h00, 4'd0, 1'b0);
        run_sweep(2, 2, 0, 1'b0, r, e, er);
        get_obs(abc, busy, done, res, err, ec);
        chk("post_abort_result", 32'(res), 32'h90);
        idle_check(2, r, e, er);

        // Randomized sweeps across both DUTs and all X sources.
        for (int n = 0; n < 8; n++) begin
            int s, md;
            s  = ($urandom_range(1, 0) == 1) ? 1 : 2;
            md = int'($urandom_range(3, 0));
            run_sweep(s, (s == 1) ? 1 : 2, md, 1'b0, r, e, er);
            idle_check(int'($urandom_range(4, 1)), r, e, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
